code_entry_ctrl: RTL

Sequential front end of the digital lock box. Collects three 3-bit digits from the switches, one per debounced Enter press, and holds them as the entered code. It also owns the stored code and lets the user reprogram it only while unlocked. It drives both code sets into the lock box comparator, samples the comparator's `match` result, and controls the unlocked and lockout indications.

---
 rtl/lockbox_pkg.sv | 23 ++
 rtl/enter_edge_sync.sv | 28 ++
 rtl/code_entry_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lockbox_pkg.sv
// lockbox_pkg: shared digit/code widths, FSM state type and reset code
// for the lock box front end.
package lockbox_pkg;

  localparam int DIGIT_W    = 3;
  localparam int NUM_DIGITS = 3;
  localparam int CODE_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [CODE_W-1:0] DEFAULT_CODE_C = '0;

  typedef enum logic [3:0] {
    ST_ENTER1,
    ST_ENTER2,
    ST_ENTER3,
    ST_CHECK,
    ST_UNLOCKED,
    ST_SET1,
    ST_SET2,
    ST_SET3,
    ST_LOCKOUT
  } code_state_t;

endpackage

// File: rtl/enter_edge_sync.sv
// enter_edge_sync: two-flop synchronizer plus rising-edge detect.
// Ports: clk, rst_n (async, active-low), btn_i (async level), pulse_o (1 cycle).
module enter_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: collects/checks/reprograms the 3-digit lock code.
// Ports: CLK, RST_N, sw, btn_enter, mode_set, match in; set_pass*, en_pass*,
// digit_idx, check_valid, unlocked, lockout, fail_cnt out.
// Build option: define CODE_LOCKOUT_EN for failure counting and timed lockout.
module code_entry_ctrl
  import lockbox_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = DEFAULT_CODE_C
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [DIGIT_W-1:0]             sw,
  input  logic                           btn_enter,
  input  logic                           mode_set,
  input  logic                           match,
  output logic [DIGIT_W-1:0]             set_pass1,
  output logic [DIGIT_W-1:0]             set_pass2,
  output logic [DIGIT_W-1:0]             set_pass3,
  output logic [DIGIT_W-1:0]             en_pass1,
  output logic [DIGIT_W-1:0]             en_pass2,
  output logic [DIGIT_W-1:0]             en_pass3,
  output logic [1:0]                     digit_idx,
  output logic                           check_valid,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_FAILS + 1);

  logic enter_p;

  code_state_t state_q, state_d;
  logic [CODE_W-1:0]    en_q, en_d;
  logic [CODE_W-1:0]    set_q, set_d;
  logic [2*DIGIT_W-1:0] stage_q, stage_d;

`ifdef CODE_LOCKOUT_EN
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  logic [FW-1:0] fail_q, fail_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  enter_edge_sync u_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .btn_i   (btn_enter),
    .pulse_o (enter_p)
  );

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    set_d   = set_q;
    stage_d = stage_q;
`ifdef CODE_LOCKOUT_EN
    fail_d  = fail_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_ENTER1: if (enter_p) begin
        en_d[8:6] = sw;
        state_d   = ST_ENTER2;
      end
      ST_ENTER2: if (enter_p) begin
        en_d[5:3] = sw;
        state_d   = ST_ENTER3;
      end
      ST_ENTER3: if (enter_p) begin
        en_d[2:0] = sw;
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        if (match) begin
          state_d = ST_UNLOCKED;
`ifdef CODE_LOCKOUT_EN
          fail_d  = '0;
        end else if (int'(fail_q) + 1 >= MAX_FAILS) begin
          fail_d  = FW'(MAX_FAILS);
          cnt_d   = CW'(LOCKOUT_CYCLES);
          state_d = ST_LOCKOUT;
        end else begin
          fail_d  = fail_q + FW'(1);
          en_d    = '0;
          state_d = ST_ENTER1;
        end
`else
        end else begin
          en_d    = '0;
          state_d = ST_ENTER1;
        end
`endif
      end
      ST_UNLOCKED: if (enter_p) begin
        if (mode_set) begin
          state_d = ST_SET1;
        end else begin
          en_d    = '0;
          state_d = ST_ENTER1;
        end
      end
      ST_SET1: if (enter_p) begin
        stage_d[5:3] = sw;
        state_d      = ST_SET2;
      end
      ST_SET2: if (enter_p) begin
        stage_d[2:0] = sw;
        state_d      = ST_SET3;
      end
      // whole code lands in one edge; no partial code is ever stored
      ST_SET3: if (enter_p) begin
        set_d   = {stage_q, sw};
        state_d = ST_UNLOCKED;
      end
      ST_LOCKOUT: begin
`ifdef CODE_LOCKOUT_EN
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          fail_d  = '0;
          en_d    = '0;
          state_d = ST_ENTER1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        state_d = ST_ENTER1;
`endif
      end
      default: state_d = ST_ENTER1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_ENTER1;
      en_q    <= '0;
      set_q   <= DEFAULT_CODE;
      stage_q <= '0;
`ifdef CODE_LOCKOUT_EN
      fail_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      set_q   <= set_d;
      stage_q <= stage_d;
`ifdef CODE_LOCKOUT_EN
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    digit_idx = 2'd0;
    unique case (1'b1)
      (state_q == ST_ENTER1), (state_q == ST_SET1): digit_idx = 2'd1;
      (state_q == ST_ENTER2), (state_q == ST_SET2): digit_idx = 2'd2;
      (state_q == ST_ENTER3), (state_q == ST_SET3): digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
  end

  assign check_valid = (state_q == ST_CHECK);
  assign unlocked    = (state_q == ST_UNLOCKED) || (state_q == ST_SET1) ||
                       (state_q == ST_SET2)     || (state_q == ST_SET3);

`ifdef CODE_LOCKOUT_EN
  assign lockout  = (state_q == ST_LOCKOUT);
  assign fail_cnt = fail_q;
`else
  assign lockout  = 1'b0;
  assign fail_cnt = '0;
`endif

  assign set_pass1 = set_q[8:6];
  assign set_pass2 = set_q[5:3];
  assign set_pass3 = set_q[2:0];
  assign en_pass1  = en_q[8:6];
  assign en_pass2  = en_q[5:3];
  assign en_pass3  = en_q[2:0];

endmodule
